// File: rtl/nibble_pkg.sv
// Shared definitions for the nibble CPU sequencer: state encoding,
// control-word bit positions and the microcode ROM address packing.
package nibble_pkg;

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } seq_state_e;

    localparam int CW_W        = 13;
    localparam int ROM_ADDR_W  = 7;

    localparam int CW_INCPC     = 12;
    localparam int CW_LOADPC    = 11;
    localparam int CW_LOADA     = 10;
    localparam int CW_LOADFLAGS = 9;
    localparam int CW_S_HI      = 8;
    localparam int CW_S_LO      = 6;
    localparam int CW_CSRAM     = 5;
    localparam int CW_WERAM     = 4;
    localparam int CW_OEALU     = 3;
    localparam int CW_OEIN      = 2;
    localparam int CW_OEOPRND   = 1;
    localparam int CW_LOADOUT   = 0;

    // ROM address order: opcode in the top nibble, then C, Z, phase.
    function automatic logic [ROM_ADDR_W-1:0] rom_addr_pack(
        input logic [3:0] opcode,
        input logic       c_flag,
        input logic       z_flag,
        input logic       ph
    );
        return {opcode, c_flag, z_flag, ph};
    endfunction

endpackage

// File: rtl/nibble_pc.sv
// Program counter register: load beats increment, otherwise hold.
// Increment wraps modulo 2^PC_W.
module nibble_pc #(
    parameter int               PC_W     = 12,
    parameter logic [PC_W-1:0]  RESET_PC = {PC_W{1'b0}}
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inc_i,
    input  logic            load_i,
    input  logic [PC_W-1:0] load_val_i,
    output logic [PC_W-1:0] pc_o
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    // Next PC selection with load priority.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
        end else begin
            pc_d = pc_q;
        end
    end

    // PC register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/nibble_sequencer.sv
// Fetch/execute sequencer for the 4-bit nibble CPU with program-memory wait
// handshake and halt/run control. Optional single-step: SEQ_SINGLE_STEP_EN.
module nibble_sequencer
    import nibble_pkg::*;
#(
    parameter int               PC_W     = 12,
    parameter logic [PC_W-1:0]  RESET_PC = {PC_W{1'b0}}
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                  step,
`endif
    output logic [PC_W-1:0]       pm_addr,
    input  logic [7:0]            pm_data,
    input  logic                  pm_ready,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    input  logic [CW_W-1:0]       rom_ctrl,
    input  logic                  alu_c,
    input  logic                  alu_z,
    output logic [3:0]            operand,
    output logic [CW_W-1:0]       ctrl_out,
    output logic                  phase,
    output logic                  halted
);

    seq_state_e      state_q, state_d;
    logic [7:0]      ir_q, ir_d;
    logic            c_q, c_d;
    logic            z_q, z_d;
    logic            advance_s;
    logic            start_s;
    logic            pc_inc_s;
    logic            pc_load_s;
    logic [PC_W-1:0] pc_s;
    logic [PC_W-1:0] jump_target_s;

`ifdef SEQ_SINGLE_STEP_EN
    // A step pulse leaves HALT; with run low, EXEC falls back to HALT afterwards.
    assign start_s = run | step;
`else
    assign start_s = run;
`endif

    assign advance_s     = (state_q != ST_HALT) && pm_ready;
    assign jump_target_s = PC_W'({ir_q[3:0], pm_data});

    // Next-state, IR, flag and PC control decode.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        c_d       = c_q;
        z_d       = z_q;
        pc_inc_s  = 1'b0;
        pc_load_s = 1'b0;
        case (state_q)
            ST_HALT: begin
                if (start_s) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_HALT;
                end
            end
            ST_FETCH: begin
                if (advance_s) begin
                    ir_d     = pm_data;
                    pc_inc_s = rom_ctrl[CW_INCPC];
                    state_d  = ST_EXEC;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC: begin
                if (advance_s) begin
                    pc_load_s = rom_ctrl[CW_LOADPC];
                    pc_inc_s  = rom_ctrl[CW_INCPC];
                    if (rom_ctrl[CW_LOADFLAGS]) begin
                        c_d = alu_c;
                        z_d = alu_z;
                    end else begin
                        c_d = c_q;
                        z_d = z_q;
                    end
                    if (run) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_HALT;
                    end
                end else begin
                    state_d = ST_EXEC;
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    // State, instruction register and flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_HALT;
            ir_q    <= 8'h00;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            c_q     <= c_d;
            z_q     <= z_d;
        end
    end

    nibble_pc #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .reset      (reset),
        .inc_i      (pc_inc_s),
        .load_i     (pc_load_s),
        .load_val_i (jump_target_s),
        .pc_o       (pc_s)
    );

    assign pm_addr  = pc_s;
    assign phase    = (state_q == ST_EXEC);
    assign halted   = (state_q == ST_HALT);
    assign operand  = ir_q[3:0];
    assign rom_addr = rom_addr_pack(ir_q[7:4], c_q, z_q, phase);
    assign ctrl_out = advance_s ? rom_ctrl : {CW_W{1'b0}};

endmodule

// File: tb/tb_nibble_sequencer.sv
// Directed self-checking bench for nibble_sequencer (hand-computed vectors).
`timescale 1ns/1ps
module tb_nibble_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        step;
    logic [11:0] pm_addr;
    logic [7:0]  pm_data;
    logic        pm_ready;
    logic [6:0]  rom_addr;
    logic [12:0] rom_ctrl;
    logic        alu_c;
    logic        alu_z;
    logic [3:0]  operand;
    logic [12:0] ctrl_out;
    logic        phase;
    logic        halted;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    nibble_sequencer #(.PC_W(12), .RESET_PC(12'h000)) dut (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
`ifdef SEQ_SINGLE_STEP_EN
        .step     (step),
`endif
        .pm_addr  (pm_addr),
        .pm_data  (pm_data),
        .pm_ready (pm_ready),
        .rom_addr (rom_addr),
        .rom_ctrl (rom_ctrl),
        .alu_c    (alu_c),
        .alu_z    (alu_z),
        .operand  (operand),
        .ctrl_out (ctrl_out),
        .phase    (phase),
        .halted   (halted)
    );

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int adv;
        reset    = 1'b0;
        run      = 1'b0;
        step     = 1'b0;
        pm_ready = 1'b0;
        pm_data  = 8'h00;
        rom_ctrl = 13'h0000;
        alu_c    = 1'b0;
        alu_z    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_val("rst_halted", halted, 1);
        chk_val("rst_pm_addr", pm_addr, 12'h000);
        chk_val("rst_phase", phase, 0);
        chk_val("rst_ctrl_out", ctrl_out, 13'h0000);
        chk_val("rst_rom_addr", rom_addr, 7'h00);

        // Idle in HALT with everything else active: no strobes, PC frozen.
        reset    = 1'b1;
        pm_ready = 1'b1;
        pm_data  = 8'hFF;
        rom_ctrl = 13'h1FFF;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk_val("halt_halted", halted, 1);
            chk_val("halt_pm_addr", pm_addr, 12'h000);
            chk_val("halt_ctrl_out", ctrl_out, 13'h0000);
            tick();
        end

        run = 1'b1;
        tick();
        chk_val("start_halted", halted, 0);
        chk_val("start_phase", phase, 0);

        pm_data  = 8'h25;
        rom_ctrl = 13'h1008;
        #1;
        chk_val("fetch_ctrl_out", ctrl_out, 13'h1008);
        tick();
        chk_val("fetch_pm_addr", pm_addr, 12'h001);
        chk_val("fetch_phase", phase, 1);
        chk_val("fetch_rom_addr", rom_addr, 7'b0010_00_1);
        chk_val("fetch_operand", operand, 4'h5);

        pm_data = 8'h00;
        tick();
        chk_val("exec_inc_pm_addr", pm_addr, 12'h002);
        chk_val("exec_inc_phase", phase, 0);

        pm_data = 8'h83;
        tick();
        chk_val("fetch83_pm_addr", pm_addr, 12'h003);
        chk_val("fetch83_rom_addr", rom_addr, 7'b1000_00_1);
        chk_val("fetch83_operand", operand, 4'h3);

        pm_data  = 8'h4C;
        rom_ctrl = 13'h0808;
        #1;
        chk_val("jump_ctrl_out", ctrl_out, 13'h0808);
        tick();
        chk_val("jump_pm_addr", pm_addr, 12'h34C);
        chk_val("jump_phase", phase, 0);
        chk_val("jump_halted", halted, 0);

        pm_data  = 8'h9A;
        rom_ctrl = 13'h1008;
        tick();
        chk_val("fetch9a_pm_addr", pm_addr, 12'h34D);
        chk_val("fetch9a_rom_addr", rom_addr, 7'b1001_00_1);

        rom_ctrl = 13'h1208;
        alu_c    = 1'b1;
        alu_z    = 1'b0;
        tick();
        chk_val("flags_pm_addr", pm_addr, 12'h34E);
        chk_val("flags_rom_addr", rom_addr, 7'b1001_10_0);

        // loadFlags in the fetch word must be ignored.
        alu_c = 1'b0;
        alu_z = 1'b1;
        tick();
        chk_val("fetchflags_rom_addr", rom_addr, 7'b1001_10_1);
        chk_val("fetchflags_pm_addr", pm_addr, 12'h34F);

        rom_ctrl = 13'h1008;
        alu_z    = 1'b0;
        tick();
        chk_val("exec34f_pm_addr", pm_addr, 12'h350);

        pm_ready = 1'b0;
        pm_data  = 8'h11;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_val("wait_ctrl_out", ctrl_out, 13'h0000);
            chk_val("wait_pm_addr", pm_addr, 12'h350);
            chk_val("wait_phase", phase, 0);
            chk_val("wait_operand", operand, 4'hA);
            tick();
        end
        pm_ready = 1'b1;
        #1;
        chk_val("wait_end_ctrl_out", ctrl_out, 13'h1008);
        tick();
        chk_val("wait_adv_pm_addr", pm_addr, 12'h351);
        chk_val("wait_adv_rom_addr", rom_addr, 7'b0001_10_1);
        chk_val("wait_adv_operand", operand, 4'h1);

        // EXEC wait, then loadPC and incPC together: load must win.
        pm_ready = 1'b0;
        pm_data  = 8'hFF;
        rom_ctrl = 13'h1808;
        tick();
        chk_val("execwait_pm_addr", pm_addr, 12'h351);
        chk_val("execwait_phase", phase, 1);
        pm_ready = 1'b1;
        tick();
        chk_val("prio_pm_addr", pm_addr, 12'h1FF);
        chk_val("prio_phase", phase, 0);

        rom_ctrl = 13'h1008;
        tick();
        chk_val("fetchff_operand", operand, 4'hF);
        rom_ctrl = 13'h0808;
        tick();
        chk_val("jumpfff_pm_addr", pm_addr, 12'hFFF);

        pm_data  = 8'h22;
        rom_ctrl = 13'h1008;
        tick();
        chk_val("wrap_pm_addr", pm_addr, 12'h000);
        chk_val("wrap_phase", phase, 1);

        run = 1'b0;
        tick();
        chk_val("runoff_halted", halted, 1);
        chk_val("runoff_pm_addr", pm_addr, 12'h001);
        chk_val("runoff_phase", phase, 0);
        tick();
        chk_val("runoff2_halted", halted, 1);
        chk_val("runoff2_pm_addr", pm_addr, 12'h001);
        chk_val("runoff2_ctrl_out", ctrl_out, 13'h0000);

        // run dropped during FETCH: instruction still completes.
        run = 1'b1;
        tick();
        run     = 1'b0;
        pm_data = 8'h30;
        tick();
        chk_val("midfetch_halted", halted, 0);
        chk_val("midfetch_phase", phase, 1);
        chk_val("midfetch_pm_addr", pm_addr, 12'h002);
        tick();
        chk_val("midfetch_end_halted", halted, 1);
        chk_val("midfetch_end_pm_addr", pm_addr, 12'h003);

`ifdef SEQ_SINGLE_STEP_EN
        step = 1'b1;
        tick();
        step = 1'b0;
        adv  = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (ctrl_out != 13'h0000) adv++;
            tick();
        end
        chk_val("step_advances", adv, 2);
        chk_val("step_halted", halted, 1);
        chk_val("step_pm_addr", pm_addr, 12'h005);
`endif

        // Asynchronous reset in the middle of an instruction.
        run     = 1'b1;
        tick();
        pm_data = 8'h57;
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk_val("arst_halted", halted, 1);
        chk_val("arst_pm_addr", pm_addr, 12'h000);
        chk_val("arst_rom_addr", rom_addr, 7'h00);
        chk_val("arst_ctrl_out", ctrl_out, 13'h0000);
        chk_val("arst_phase", phase, 0);
        tick();
        reset = 1'b1;
        tick();
        chk_val("arst_restart_halted", halted, 0);
        chk_val("arst_restart_pm_addr", pm_addr, 12'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/nibble_sequencer.md
Name: nibble_sequencer

Overview:
- Fetch/execute sequencer for the 4-bit nibble CPU.
- Owns the phase bit, the 12-bit program counter, the 8-bit instruction register and the C/Z flag register.
- Forms the 7-bit microcode ROM address {opcode[3:0], C, Z, phase} and applies the returned 13-bit control word.
- Sits between program memory, the microcode ROM and the ALU/accumulator datapath. Adds a program-memory wait handshake and a halt/run control.

Parameters:
- PC_W, 12, program counter width.
- RESET_PC, 12'h000, PC value after reset.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- run  input  1  level; 1 allows instruction execution, 0 requests halt at the next instruction boundary.
- pm_addr  output  12  program memory address (= pc).
- pm_data  input  8  program memory read data.
- pm_ready  input  1  pm_data is valid this cycle.
- rom_addr  output  7  {ir[7:4], c_flag, z_flag, phase}.
- rom_ctrl  input  13  control word: [12]incPC [11]loadPC [10]loadA [9]loadFlags [8:6]S [5]csRAM [4]weRAM [3]oeALU [2]oeIN [1]oeOprnd [0]loadOut.
- alu_c, alu_z  input  1 each  ALU carry and zero results.
- operand  output  4  ir[3:0] to the datapath bus driver.
- ctrl_out  output  13  rom_ctrl gated by an advance cycle, else 0.
- phase  output  1  0 = fetch, 1 = execute.
- halted  output  1  high in HALT state.

Behaviour:
- States: HALT, FETCH, EXEC. Phase = 1 only in EXEC.
- Reset values:
  - state = HALT, pc = RESET_PC, ir = 8'h00, c_flag = z_flag = 0.
  - phase = 0, halted = 1, ctrl_out = 0.
- advance = (state != HALT) && pm_ready.
- ctrl_out = advance ? rom_ctrl : 13'h0, combinational.
  - Datapath strobes fire only in cycles that advance.
- HALT:
  - Go to FETCH when run = 1 in the next cycle.
  - pc is unchanged and no strobes are issued.
- FETCH:
  - If advance: ir <= pm_data; pc <= pc+1 when rom_ctrl[12]; go to EXEC.
  - If pm_ready = 0: hold all state (wait state, unbounded).
- EXEC:
  - If advance:
    - if rom_ctrl[11]: pc <= {ir[3:0], pm_data[7:0]} (jump target is the operand nibble plus the following program byte);
    - else if rom_ctrl[12]: pc <= pc+1.
    - if rom_ctrl[9]: c_flag <= alu_c, z_flag <= alu_z.
    - Next state is FETCH if run = 1, else HALT.
  - If pm_ready = 0: hold all state.
- loadPC has priority over incPC when both are set.
- pc wraps modulo 2^PC_W: 12'hFFF+1 = 12'h000.
- Jump target 12 bits with PC_W = 12. For larger PC_W, zero-extend the target.
- run deasserted mid-instruction: the current EXEC completes, then the block halts. An instruction is never split.
- Flags update only on EXEC with loadFlags. The fetch control word never loads flags.
- rom_addr is driven combinationally from registered state, so there is no ROM latency inside the block.
- Reset mid-operation: state is forced to reset values asynchronously. Deassertion is taken on the next clk edge.

Optional Feature:
- SEQ_SINGLE_STEP_EN:
  - Defined: adds input `step` (1 bit).
  - In HALT, a one-cycle step pulse with run = 0 executes exactly one instruction (FETCH, EXEC) and returns to HALT.
  - step is ignored outside HALT.
- Undefined: no step port. Only run controls execution.

Decomposition:
- Shared package nibble_pkg holds:
  - state enum (HALT, FETCH, EXEC);
  - control-word bit index localparams (CW_INCPC=12 … CW_LOADOUT=0);
  - the ROM address packing order.
- One natural sub-module, nibble_pc (PC_W register with inc/load/hold and priority), instantiated once.

Test Plan:
- Reset low then high, run = 0 -> halted = 1, pm_addr = 12'h000, ctrl_out = 0 for 10 cycles.
- run = 1, pm_ready = 1, pm_data = 8'h25, rom_ctrl mimicking the fetch word 13'h1008 -> ir = 8'h25, pc = 1, phase = 1 next cycle, rom_addr = 7'b0010_00_1.
- Taken jump:
  - Stimulus: EXEC with ir = 8'h83, pm_data = 8'h4C, rom_ctrl = 13'h0808.
  - Required: pc = 12'h34C, then FETCH.
- Same with rom_ctrl = 13'h1008 -> pc increments by 1.
- Flags update:
  - Stimulus: EXEC with loadFlags set, alu_c = 1, alu_z = 0.
  - Required: c_flag = 1, and rom_addr bit2 = 1 in the next EXEC.
- pm_ready held 0 for 3 cycles in FETCH -> pc, ir and state hold; ctrl_out = 0 during the wait; advance occurs on the 4th cycle.
- Boundary and control cases:
  - pc = 12'hFFF with incPC -> pc = 12'h000.
  - run dropped during EXEC -> the instruction completes, then halted = 1.
  - With SEQ_SINGLE_STEP_EN, one step pulse -> exactly two advance cycles.
